// File: rtl/div_freq_prog.sv
// Runtime-programmable clock divider / PWM generator.
// The period and on-time are staged in a shadow register and only become
// active at a period boundary (or while idle), so Clkout never glitches.
// Adds a run gate, a one-shot mode, a wrap strobe and load-error reporting.
module div_freq_prog #(
    parameter int unsigned     BUS_SIZE = 32,
    parameter longint unsigned NBT      = 50000000,
    parameter longint unsigned NBTON    = 25000000,
    parameter bit              POLARITY = 1'b0
) (
    input  logic                Clkin,
    input  logic                Rst,
    input  logic                En,
    input  logic                OneShot,
    input  logic                Load,
    input  logic [BUS_SIZE-1:0] PeriodIn,
    input  logic [BUS_SIZE-1:0] OnIn,
    output logic                Clkout,
    output logic                Tick,
    output logic                Running,
    output logic                Done,
    output logic                Pending,
    output logic                Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [BUS_SIZE-1:0] cnt;
    logic [BUS_SIZE-1:0] cnt_d;
    logic [BUS_SIZE-1:0] per_cur;
    logic [BUS_SIZE-1:0] per_cur_d;
    logic [BUS_SIZE-1:0] on_cur;
    logic [BUS_SIZE-1:0] on_cur_d;
    logic [BUS_SIZE-1:0] per_sh;
    logic [BUS_SIZE-1:0] on_sh;
    logic [BUS_SIZE-1:0] last_cnt;
    logic                load_ok;
    logic                apply;
    logic                pending_d;
    logic                clkout_d;
    logic                tick_d;
    logic                err_d;

    // A period is PerCur cycles long, so the final count value is PerCur-1.
    assign last_cnt = per_cur - BUS_SIZE'(1);

    // Load validation: a period below 2 or an on-time longer than the period is refused.
    assign load_ok = Load && (PeriodIn >= BUS_SIZE'(2)) && (OnIn <= PeriodIn);

    // Next-state, counter, shadow-application and registered-output logic.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        apply     = 1'b0;
        tick_d    = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                apply = Pending;
                if (En) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!En) begin
                    // Abandon the partial period silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt >= last_cnt) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    apply  = Pending;
                    if (OneShot) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt + BUS_SIZE'(1);
                end
            end
            DONE: begin
                cnt_d = '0;
                if (!En) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        per_cur_d = apply ? per_sh : per_cur;
        on_cur_d  = apply ? on_sh  : on_cur;

        // A load at the same edge as an application re-arms Pending with the
        // new shadow, which is then used at the following boundary.
        if (load_ok) begin
            pending_d = 1'b1;
        end else if (apply) begin
            pending_d = 1'b0;
        end else begin
            pending_d = Pending;
        end

        err_d = Load && !load_ok;

        // Computed from the next count and on-time so Clkout lines up with Cnt.
        if ((state_d == RUN) && (cnt_d < on_cur_d)) begin
            clkout_d = POLARITY;
        end else begin
            clkout_d = ~POLARITY;
        end
    end

    // Control state and registered outputs, with synchronous reset.
    always_ff @(posedge Clkin) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            per_cur <= BUS_SIZE'(NBT);
            on_cur  <= BUS_SIZE'(NBTON);
            Pending <= 1'b0;
            Clkout  <= ~POLARITY;
            Tick    <= 1'b0;
            Err     <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            per_cur <= per_cur_d;
            on_cur  <= on_cur_d;
            Pending <= pending_d;
            Clkout  <= clkout_d;
            Tick    <= tick_d;
            Err     <= err_d;
        end
    end

    // Shadow capture; contents only matter while Pending is set, so no reset.
    always_ff @(posedge Clkin) begin
        if (!Rst && load_ok) begin
            per_sh <= PeriodIn;
            on_sh  <= OnIn;
        end
    end

    assign Running = (state == RUN);
    assign Done    = (state == DONE);

endmodule
